// File: rtl/blit_rect_seq.sv
// blit_rect_seq: rectangle fill sequencer. Walks a width x height rectangle
// row-major from dst_addr. It emits one fill byte per unstalled cycle to a
// downstream byte combiner. It then spends one flush cycle with out_active
// low and pulses done.
// Optional feature: define BLIT_CLIP_EN to add clip_x/clip_y. With it,
// pixels outside the clip window still take a RUN cycle but are not enabled.
module blit_rect_seq (
  input  logic        clock,
  input  logic        resetn,
  input  logic        stall,
  input  logic        start,
  input  logic [25:0] dst_addr,
  input  logic [11:0] width,
  input  logic [11:0] height,
  input  logic [15:0] stride,
  input  logic [7:0]  colour,
`ifdef BLIT_CLIP_EN
  input  logic [11:0] clip_x,
  input  logic [11:0] clip_y,
`endif
  output logic [25:0] out_addr,
  output logic [7:0]  out_data,
  output logic        out_en,
  output logic        out_active,
  output logic        busy,
  output logic        done
);

  localparam int ADDR_W = 26;
  localparam int DIM_W  = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DIM_W-1:0]    x_q, x_d;
  logic [DIM_W-1:0]    y_q, y_d;
  logic [ADDR_W-1:0]   row_addr_q, row_addr_d;
  logic [DIM_W-1:0]    width_q, width_d;
  logic [DIM_W-1:0]    height_q, height_d;
  logic [15:0]         stride_q, stride_d;
  logic [7:0]          colour_q, colour_d;
  logic                done_q, done_d;
`ifdef BLIT_CLIP_EN
  logic [DIM_W-1:0]    clip_x_q, clip_x_d;
  logic [DIM_W-1:0]    clip_y_q, clip_y_d;
`endif

  logic                last_col;
  logic                last_row;
  logic                dims_ok;
  logic                pix_en;
  logic [ADDR_W-1:0]   pix_addr;

  // Position decode and current pixel address (modulo 2^26 by truncation)
  always_comb begin
    last_col = (x_q == (width_q - 12'd1));
    last_row = (y_q == (height_q - 12'd1));
    dims_ok  = (width != 12'd0) && (height != 12'd0);
    pix_addr = row_addr_q + {{(ADDR_W-DIM_W){1'b0}}, x_q};
`ifdef BLIT_CLIP_EN
    pix_en   = (x_q < clip_x_q) && (y_q < clip_y_q);
`else
    pix_en   = 1'b1;
`endif
  end

  // Next-state, datapath updates and Moore outputs
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    row_addr_d = row_addr_q;
    width_d    = width_q;
    height_d   = height_q;
    stride_d   = stride_q;
    colour_d   = colour_q;
    done_d     = 1'b0;
`ifdef BLIT_CLIP_EN
    clip_x_d   = clip_x_q;
    clip_y_d   = clip_y_q;
`endif
    out_en     = 1'b0;
    out_active = 1'b0;
    out_addr   = '0;
    out_data   = '0;
    busy       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (dims_ok) begin
            width_d    = width;
            height_d   = height;
            stride_d   = stride;
            colour_d   = colour;
            row_addr_d = dst_addr;
            x_d        = '0;
            y_d        = '0;
`ifdef BLIT_CLIP_EN
            clip_x_d   = clip_x;
            clip_y_d   = clip_y;
`endif
            state_d    = ST_RUN;
          end else begin
            // Empty rectangle: nothing to draw, just acknowledge
            done_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        busy       = 1'b1;
        out_active = 1'b1;
        out_en     = pix_en;
        out_addr   = pix_addr;
        out_data   = colour_q;
        if (!stall) begin
          if (last_col) begin
            x_d        = '0;
            y_d        = y_q + 12'd1;
            row_addr_d = row_addr_q + {{(ADDR_W-16){1'b0}}, stride_q};
            if (last_row) begin
              state_d = ST_FLUSH;
            end
          end else begin
            x_d = x_q + 12'd1;
          end
        end
      end

      ST_FLUSH: begin
        // out_active low here tells the combiner to push out its partial word
        busy = 1'b1;
        if (!stall) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign done = done_q;

  // State and datapath registers, all cleared by the asynchronous reset
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      row_addr_q <= '0;
      width_q    <= '0;
      height_q   <= '0;
      stride_q   <= '0;
      colour_q   <= '0;
      done_q     <= 1'b0;
`ifdef BLIT_CLIP_EN
      clip_x_q   <= '0;
      clip_y_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_addr_q <= row_addr_d;
      width_q    <= width_d;
      height_q   <= height_d;
      stride_q   <= stride_d;
      colour_q   <= colour_d;
      done_q     <= done_d;
`ifdef BLIT_CLIP_EN
      clip_x_q   <= clip_x_d;
      clip_y_q   <= clip_y_d;
`endif
    end
  end

endmodule

// File: tb/tb_blit_rect_seq.sv
// Testbench for blit_rect_seq: directed and randomized blits checked against
// a reference list of pixel addresses computed as dst + y*stride + x.
module tb_blit_rect_seq;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        stall = 1'b0;
  logic        start = 1'b0;
  logic [25:0] dst_addr = '0;
  logic [11:0] width = '0;
  logic [11:0] height = '0;
  logic [15:0] stride = '0;
  logic [7:0]  colour = '0;
`ifdef BLIT_CLIP_EN
  logic [11:0] clip_x = 12'hFFF;
  logic [11:0] clip_y = 12'hFFF;
`endif
  logic [25:0] out_addr;
  logic [7:0]  out_data;
  logic        out_en;
  logic        out_active;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  blit_rect_seq dut (
    .clock      (clock),
    .resetn     (resetn),
    .stall      (stall),
    .start      (start),
    .dst_addr   (dst_addr),
    .width      (width),
    .height     (height),
    .stride     (stride),
    .colour     (colour),
`ifdef BLIT_CLIP_EN
    .clip_x     (clip_x),
    .clip_y     (clip_y),
`endif
    .out_addr   (out_addr),
    .out_data   (out_data),
    .out_en     (out_en),
    .out_active (out_active),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Full blit. mode 0: no stall, 1: random stall, 2: 3-cycle stall on 2nd pixel
  task automatic run_blit(input logic [25:0] d, input logic [11:0] w, input logic [11:0] h,
                          input logic [15:0] s, input logic [7:0] c,
                          input logic [11:0] cx, input logic [11:0] cy, input int mode);
    logic [25:0] ea[$];
    bit          ee[$];
    longint      a;
    int          k, held, cyc;
    bit          st;
    for (int yy = 0; yy < int'(h); yy++) begin
      for (int xx = 0; xx < int'(w); xx++) begin
        a = longint'(d) + longint'(yy) * longint'(s) + longint'(xx);
        ea.push_back(a[25:0]);
        ee.push_back((xx < int'(cx)) && (yy < int'(cy)));
      end
    end
    @(negedge clock);
    check("idle_busy", busy, 1'b0);
    dst_addr = d; width = w; height = h; stride = s; colour = c;
`ifdef BLIT_CLIP_EN
    clip_x = cx; clip_y = cy;
`endif
    start = 1'b1;
    stall = 1'b0;
    @(negedge clock);
    k = 0; held = 0; cyc = 0;
    while (k < ea.size() && cyc < 2000) begin
      check("run_active", out_active, 1'b1);
      check("run_en", out_en, ee[k]);
      check("run_addr", out_addr, ea[k]);
      check("run_data", out_data, c);
      check("run_busy", busy, 1'b1);
      check("run_done", done, 1'b0);
      case (mode)
        0: st = 1'b0;
        1: st = ($urandom_range(0, 2) == 0);
        default: begin
          st = (k == 1) && (held < 3);
          if (st) held++;
        end
      endcase
      stall = st;
      // Scrambled request inputs while busy must have no effect
      start = $urandom_range(0, 1);
      dst_addr = $urandom; width = $urandom; height = $urandom;
      stride = $urandom; colour = $urandom;
      if (!st) k++;
      cyc++;
      @(negedge clock);
    end
    check("run_budget", cyc < 2000, 1'b1);
    start = 1'b0;
    check("flush_active", out_active, 1'b0);
    check("flush_en", out_en, 1'b0);
    check("flush_busy", busy, 1'b1);
    check("flush_done", done, 1'b0);
    if (mode == 1 && $urandom_range(0, 1) == 1) begin
      stall = 1'b1;
      @(negedge clock);
      check("flush_hold_busy", busy, 1'b1);
      check("flush_hold_done", done, 1'b0);
    end
    stall = 1'b0;
    @(negedge clock);
    check("end_done", done, 1'b1);
    check("end_busy", busy, 1'b0);
    check("end_active", out_active, 1'b0);
    check("end_en", out_en, 1'b0);
    @(negedge clock);
    check("end_done_clr", done, 1'b0);
  endtask

  task automatic run_zero(input logic [11:0] w, input logic [11:0] h);
    @(negedge clock);
    width = w; height = h; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("zero_done", done, 1'b1);
    check("zero_busy", busy, 1'b0);
    check("zero_en", out_en, 1'b0);
    check("zero_active", out_active, 1'b0);
    @(negedge clock);
    check("zero_done_clr", done, 1'b0);
    check("zero_busy2", busy, 1'b0);
    check("zero_en2", out_en, 1'b0);
  endtask

  initial begin
    // Reset state
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_en", out_en, 1'b0);
    check("rst_active", out_active, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_addr", out_addr, 26'h0);
    check("rst_data", out_data, 8'h0);
    resetn = 1'b1;

    // Basic 3x2 blit, no stall
    run_blit(26'h100, 12'd3, 12'd2, 16'h40, 8'hA5, 12'hFFF, 12'hFFF, 0);
    // Same blit with a 3-cycle stall on the second pixel
    run_blit(26'h100, 12'd3, 12'd2, 16'h40, 8'hA5, 12'hFFF, 12'hFFF, 2);
    // Empty rectangles
    run_zero(12'd0, 12'd5);
    run_zero(12'd3, 12'd0);
    // Address wrap at 2^26
    run_blit(26'h3FFFFFE, 12'd4, 12'd1, 16'h10, 8'h5A, 12'hFFF, 12'hFFF, 0);

    // Reset in the middle of a blit
    @(negedge clock);
    dst_addr = 26'h200; width = 12'd4; height = 12'd3; stride = 16'h20; colour = 8'h33;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("mid_addr0", out_addr, 26'h200);
    @(negedge clock);
    check("mid_addr1", out_addr, 26'h201);
    @(negedge clock);
    check("mid_addr2", out_addr, 26'h202);
    resetn = 1'b0;
    #1;
    check("mid_rst_en", out_en, 1'b0);
    check("mid_rst_active", out_active, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_addr", out_addr, 26'h0);
    check("mid_rst_data", out_data, 8'h0);
    @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("mid_no_done", done, 1'b0);
      check("mid_no_busy", busy, 1'b0);
      @(negedge clock);
    end
    run_blit(26'h300, 12'd2, 12'd2, 16'h8, 8'hC3, 12'hFFF, 12'hFFF, 0);

`ifdef BLIT_CLIP_EN
    run_blit(26'h400, 12'd4, 12'd2, 16'h100, 8'h11, 12'd2, 12'd1, 0);
    run_blit(26'h500, 12'd5, 12'd3, 16'h20, 8'h22, 12'd3, 12'd2, 1);
`endif

    // Randomized blits with random stalls
    for (int n = 0; n < 8; n++) begin
      run_blit(26'($urandom), 12'($urandom_range(1, 7)), 12'($urandom_range(1, 4)),
               16'($urandom), 8'($urandom), 12'hFFF, 12'hFFF, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/blit_rect_seq.md
BLIT_RECT_SEQ -- requirements
Module: blit_rect_seq

Interface
REQ-001 SHALL have port clock, input, 1: single clock, all state on rising edge.
REQ-002 SHALL have port resetn, input, 1: asynchronous active-low reset.
REQ-003 SHALL have port stall, input, 1: downstream stall, shared with the byte combiner.
REQ-004 SHALL have port start, input, 1: blit request, sampled only in IDLE.
REQ-005 SHALL have port dst_addr, input, 26: byte address of top-left pixel.
REQ-006 SHALL have port width, input, 12: pixels per row.
REQ-007 SHALL have port height, input, 12: row count.
REQ-008 SHALL have port stride, input, 16: bytes between row starts, unsigned.
REQ-009 SHALL have port colour, input, 8: fill byte.
REQ-010 SHALL have port out_addr, output, 26: pixel byte address to combiner.
REQ-011 SHALL have port out_data, output, 8: pixel byte to combiner.
REQ-012 SHALL have port out_en, output, 1: pixel valid this cycle.
REQ-013 SHALL have port out_active, output, 1: blit in progress; 0 tells the combiner to flush.
REQ-014 SHALL have port busy, output, 1: high from accepted start until done.
REQ-015 SHALL have port done, output, 1: one-cycle pulse at blit end.

Function
REQ-016 SHALL implement states IDLE, RUN, FLUSH.
REQ-017 SHALL, in IDLE with start=1 and width!=0 and height!=0, latch dst_addr/width/height/stride/colour, clear x and y, set row_addr=dst_addr, and enter RUN next cycle.
REQ-018 SHALL, in IDLE with start=1 and width==0 or height==0, emit no pixel, stay in IDLE, and pulse done the following cycle.
REQ-019 SHALL, in RUN, drive out_en=1, out_active=1, out_data=latched colour, out_addr=(row_addr+x) mod 2^26.
REQ-020 SHALL advance only on cycles with stall=0; with stall=1 all state and outputs hold.
REQ-021 SHALL on advance increment x; at x==width-1 set x=0, y=y+1, row_addr=(row_addr+stride) mod 2^26.
REQ-022 SHALL on advance at x==width-1 and y==height-1 enter FLUSH.
REQ-023 SHALL in FLUSH drive out_en=0, out_active=0, busy=1; on stall=0 enter IDLE with done=1 for exactly that following cycle.
REQ-024 SHALL in IDLE drive out_en=0, out_active=0, busy=0.
REQ-025 SHALL ignore start while busy.
REQ-026 SHALL emit pixels row-major, first pixel one cycle after start, width*height pixels total, one per unstalled RUN cycle.
REQ-027 SHALL drive done independently of stall once asserted (single-cycle pulse).

Reset
REQ-028 SHALL on resetn=0, immediately: state=IDLE, x=y=0, out_en=0, out_active=0, busy=0, done=0, out_addr=0, out_data=0.
REQ-029 SHALL on reset mid-blit abandon the blit with no flush cycle and no done pulse.

Configuration
REQ-030 SHALL, with macro BLIT_CLIP_EN defined, add inputs clip_x (12) and clip_y (12), latched at start; pixels with x>=clip_x or y>=clip_y still take one RUN cycle but drive out_en=0.
REQ-031 SHALL, without BLIT_CLIP_EN, omit clip_x/clip_y and enable every pixel.

Verification
REQ-032 SHALL test: dst_addr=0x100, width=3, height=2, stride=0x40, colour=0xA5 -> out_en addresses 0x100,0x101,0x102,0x140,0x141,0x142 on consecutive cycles, then one out_active=0 cycle, then done.
REQ-033 SHALL test: same blit, stall=1 for 3 cycles during the 2nd pixel -> out_addr held at 0x101 for 4 cycles, total 6 pixels, sequence unchanged.
REQ-034 SHALL test: start with width=0, height=5 -> no out_en, busy stays 0, done one cycle later.
REQ-035 SHALL test: dst_addr=0x3FFFFFE, width=4, height=1 -> addresses 0x3FFFFFE,0x3FFFFFF,0x0000000,0x0000001.
REQ-036 SHALL test: resetn=0 during RUN after 2 pixels -> outputs zero at once, no done, new start afterwards runs normally.
REQ-037 SHALL test with BLIT_CLIP_EN: width=4, height=2, clip_x=2, clip_y=1 -> 8 RUN cycles, out_en high only for pixels (0,0),(1,0).
